// File: rtl/bomb_controller_pkg.sv
// bomb_controller_pkg: shared screen geometry, tile/arm extents, FSM encodings and tile snapping.
package bomb_controller_pkg;
  localparam logic [9:0] MIN_X = 10'd143;
  localparam logic [9:0] MAX_X = 10'd784;
  localparam logic [9:0] MIN_Y = 10'd34;
  localparam logic [9:0] MAX_Y = 10'd516;
  localparam logic [10:0] TILE = 11'd16;
  localparam logic [10:0] E_WN = 11'd48;
  localparam logic [10:0] E_WP = 11'd63;
  localparam logic [5:0] MAX_COL = 6'((MAX_X - MIN_X) / 16 - 1);
  localparam logic [5:0] MAX_ROW = 6'((MAX_Y - MIN_Y) / 16 - 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_EXPLODE = 2'd2;
  localparam logic [1:0] S_COOLDOWN = 2'd3;
  // Round to the nearest tile origin, clamped to the playfield grid.
  function automatic logic [9:0] snap(input logic [9:0] p, input logic [9:0] lo, input logic [5:0] lim);
    logic [10:0] t;
    logic [5:0] idx;
    t = ({1'b0, p} + 11'd8 - {1'b0, lo}) >> 4;
    idx = (p < lo) ? 6'd0 : (t > {5'd0, lim}) ? lim : t[5:0];
    return lo + {idx, 4'b0};
  endfunction
endpackage

// File: rtl/bomb_rom.sv
// bomb_rom: 16x16 bomb sprite with a registered read.
module bomb_rom (
  input  logic        clk,
  input  logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [11:0] color_data
);
  logic [3:0] dr, dc;
  logic [7:0] r2;
  assign dr = row[3] ? row - 4'd8 : 4'd7 - row;
  assign dc = col[3] ? col - 4'd8 : 4'd7 - col;
  assign r2 = {4'd0, dr} * {4'd0, dr} + {4'd0, dc} * {4'd0, dc};
  always_ff @(posedge clk)
    color_data <= (row < 4'd3 && col > 4'd10 && col < 4'd13) ? 12'hFD0 :
                  (r2 < 8'd4) ? 12'h777 : (r2 < 8'd42) ? 12'h333 : 12'h000;
endmodule

// File: rtl/bomb_controller.sv
// bomb_controller: single player bomb lifecycle, explosion interface and pixel flags.
module bomb_controller
  import bomb_controller_pkg::*;
#(
  parameter int unsigned FUSE_TICKS     = 200000000,
  parameter int unsigned EXPLODE_TICKS  = 50000000,
  parameter int unsigned COOLDOWN_TICKS = 25000000,
  parameter logic [11:0] EXPLOSION_RGB  = 12'hF80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        place_btn,
  input  logic        game_over,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic [9:0]  v_x,
  input  logic [9:0]  v_y,
  output logic [9:0]  e_x,
  output logic [9:0]  e_y,
  output logic        explosion_SCEN,
  output logic        bomb_on,
  output logic        explosion_on,
  output logic [11:0] rgb_out,
  output logic        player_hit
);
  logic [1:0] state_q, state_d;
  logic [27:0] cnt_q, cnt_d, limit;
  logic [9:0] ex_q, ex_d, ey_q, ey_d;
  logic hit_q, hit_d, place_q, place_rise, accept, armed, explode;
  logic h_ovl, v_ovl, in_h, in_v, in_tile;
  logic [10:0] bx, by, vx, vy, ex, ey;
  logic [11:0] rom_data;
  assign bx = {1'b0, b_x};
  assign by = {1'b0, b_y};
  assign vx = {1'b0, v_x};
  assign vy = {1'b0, v_y};
  assign ex = {1'b0, ex_q};
  assign ey = {1'b0, ey_q};
  assign armed = state_q == S_ARMED;
  assign explode = state_q == S_EXPLODE;
  assign place_rise = place_btn & ~place_q;
  assign accept = state_q == S_IDLE && place_rise && !game_over;
  assign limit = armed ? 28'(FUSE_TICKS - 1) : explode ? 28'(EXPLODE_TICKS - 1) : 28'(COOLDOWN_TICKS - 1);
  // Sums on both sides keep every bound test free of underflow near the screen origin.
  assign h_ovl = bx + TILE + E_WN > ex && bx < ex + E_WP + 11'd1 && by + TILE > ey && by < ey + TILE;
  assign v_ovl = bx + TILE > ex && bx < ex + TILE && by + TILE + E_WN > ey && by < ey + E_WP + 11'd1;
  assign in_h = vx + E_WN >= ex && vx <= ex + E_WP && vy >= ey && vy < ey + TILE;
  assign in_v = vy + E_WN >= ey && vy <= ey + E_WP && vx >= ex && vx < ex + TILE;
  assign in_tile = vx >= ex && vx < ex + TILE && vy >= ey && vy < ey + TILE;
  always_comb begin
    state_d = game_over ? S_IDLE :
              state_q == S_IDLE ? (place_rise ? S_ARMED : S_IDLE) :
              cnt_q != limit ? state_q :
              armed ? S_EXPLODE : explode ? S_COOLDOWN : S_IDLE;
    cnt_d = (state_d != state_q || state_q == S_IDLE) ? 28'd0 : cnt_q + 28'd1;
    ex_d = accept ? snap(b_x, MIN_X, MAX_COL) : ex_q;
    ey_d = accept ? snap(b_y, MIN_Y, MAX_ROW) : ey_q;
    hit_d = hit_q | (explode & ~game_over & (h_ovl | v_ovl));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      ex_q <= '0;
      ey_q <= '0;
      hit_q <= 1'b0;
      place_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ex_q <= ex_d;
      ey_q <= ey_d;
      hit_q <= hit_d;
      place_q <= place_btn;
    end
  bomb_rom u_rom (
    .clk(clk),
    .row(v_y[3:0] - ey_q[3:0]),
    .col(v_x[3:0] - ex_q[3:0]),
    .color_data(rom_data)
  );
  assign e_x = ex_q;
  assign e_y = ey_q;
  assign explosion_SCEN = explode;
  assign bomb_on = armed && in_tile;
  assign explosion_on = explode && (in_h || in_v);
  assign rgb_out = armed ? rom_data : EXPLOSION_RGB;
  assign player_hit = hit_q;
endmodule

// File: tb/tb_bomb_controller.sv
// tb_bomb_controller: directed plan plus random traffic against a timeline model of the bomb.
`timescale 1ns/1ps
module tb_bomb_controller;
  localparam int F = 10, E = 5, C = 3;
  logic clk = 0, reset = 1, place_btn = 0, game_over = 0, chk_en = 0;
  logic [9:0] b_x = 0, b_y = 0, v_x = 0, v_y = 0, e_x, e_y;
  logic explosion_SCEN, bomb_on, explosion_on, player_hit;
  logic [11:0] rgb_out;
  int n_checks = 0, n_fail = 0;
  bit m_active = 0, m_hit = 0, m_pd = 0, m_rise;
  int m_el = 0, m_ex = 0, m_ey = 0;
  int first_scen, n_scen, n_bomb;

  bomb_controller #(.FUSE_TICKS(F), .EXPLODE_TICKS(E), .COOLDOWN_TICKS(C)) dut (
    .clk(clk), .reset(reset), .place_btn(place_btn), .game_over(game_over),
    .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y), .e_x(e_x), .e_y(e_y),
    .explosion_SCEN(explosion_SCEN), .bomb_on(bomb_on), .explosion_on(explosion_on),
    .rgb_out(rgb_out), .player_hit(player_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Timeline view: a live bomb is ARMED, then EXPLODE, then COOLDOWN by elapsed cycles.
  function automatic int phase();
    if (!m_active) return 0;
    if (m_el < F) return 1;
    if (m_el < F + E) return 2;
    return 3;
  endfunction

  function automatic int snap(input int p, input int lo, input int lim);
    int c;
    if (p < lo) return lo;
    c = (p - lo + 8) / 16;
    return lo + ((c > lim) ? lim : c) * 16;
  endfunction

  function automatic bit ovl(input int a0, input int alen, input int b0, input int blen);
    return a0 < b0 + blen && b0 < a0 + alen;
  endfunction

  function automatic bit in_rect(input int x, input int y, input int x0, input int y0, input int w, input int h);
    return x >= x0 && x < x0 + w && y >= y0 && y < y0 + h;
  endfunction

  function automatic bit in_plus(input int x, input int y);
    return in_rect(x, y, m_ex - 48, m_ey, 112, 16) || in_rect(x, y, m_ex, m_ey - 48, 16, 112);
  endfunction

  function automatic bit hits_player(input int x, input int y);
    return (ovl(m_ex - 48, 112, x, 16) && ovl(m_ey, 16, y, 16)) ||
           (ovl(m_ex, 16, x, 16) && ovl(m_ey - 48, 112, y, 16));
  endfunction

  function automatic logic [9:0] clampv(input int v);
    return 10'((v < 0) ? 0 : (v > 1023) ? 1023 : v);
  endfunction

  always @(posedge clk or posedge reset)
    if (reset) begin
      m_active = 0; m_el = 0; m_ex = 0; m_ey = 0; m_hit = 0; m_pd = 0;
    end else begin
      if (phase() == 2 && !game_over && hits_player(b_x, b_y)) m_hit = 1;
      m_rise = place_btn && !m_pd;
      m_pd = place_btn;
      if (game_over) m_active = 0;
      else if (m_active) begin
        m_el++;
        if (m_el == F + E + C) m_active = 0;
      end else if (m_rise) begin
        m_active = 1; m_el = 0;
        m_ex = snap(b_x, 143, 39); m_ey = snap(b_y, 34, 29);
      end
    end

  always @(negedge clk)
    if (chk_en && !reset) begin
      check("scen", explosion_SCEN, phase() == 2);
      check("bomb_on", bomb_on, phase() == 1 && in_rect(v_x, v_y, m_ex, m_ey, 16, 16));
      check("expl_on", explosion_on, phase() == 2 && in_plus(v_x, v_y));
      check("e_x", e_x, m_ex);
      check("e_y", e_y, m_ey);
      check("hit", player_hit, m_hit);
      if (phase() != 1) check("rgb", rgb_out, 12'hF80);
    end

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic place();
    place_btn = 1; step(); place_btn = 0;
  endtask

  task automatic do_reset();
    reset = 1; step(); reset = 0; step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    check("rst_ex", e_x, 0);
    check("rst_ey", e_y, 0);
    check("rst_scen", explosion_SCEN, 0);
    check("rst_hit", player_hit, 0);
    check("rst_flags", {bomb_on, explosion_on}, 0);
    reset = 0; chk_en = 1; step();
    // 1: timing of one full bomb lifecycle
    b_x = 150; b_y = 40; v_x = 150; v_y = 40;
    place();
    check("t1_ex", e_x, 143);
    check("t1_ey", e_y, 34);
    first_scen = -1; n_scen = 0; n_bomb = 0;
    for (int i = 0; i < 30; i++) begin
      if (explosion_SCEN && first_scen < 0) first_scen = i;
      n_scen += int'(explosion_SCEN);
      n_bomb += int'(bomb_on);
      step();
    end
    check("t1_first_scen", first_scen, F);
    check("t1_n_scen", n_scen, E);
    check("t1_n_bomb", n_bomb, F);
    // 2: snapping and clamping
    b_x = 152; b_y = 51; place();
    check("t2_ex", e_x, 159);
    check("t2_ey", e_y, 50);
    game_over = 1; step(); game_over = 0; step();
    b_x = 780; b_y = 510; place();
    check("t2_ex_clamp", e_x, 767);
    check("t2_ey_clamp", e_y, 498);
    game_over = 1; step(); game_over = 0; step();
    // 3: player inside the horizontal arm
    b_x = 207; b_y = 98; place();
    check("t3_ex", e_x, 207);
    check("t3_ey", e_y, 98);
    b_x = 256; step(F + 1);
    check("t3_hit", player_hit, 1);
    step(10);
    do_reset();
    // 3b + 5: player just past the arm, plus-shape edges
    b_x = 207; b_y = 98; place();
    b_x = 271; v_x = 0; v_y = 0; step(F);
    v_x = 159; v_y = 100; step(); check("t5_in_h", explosion_on, 1);
    v_x = 158; step(); check("t5_out_h", explosion_on, 0);
    v_x = 210; v_y = 161; step(); check("t5_in_v", explosion_on, 1);
    v_y = 162; step(); check("t5_out_v", explosion_on, 0);
    step(8);
    check("t3_nohit", player_hit, 0);
    // 4: held button and a cooldown pulse are ignored
    b_x = 150; b_y = 40; v_x = 150; v_y = 40;
    place_btn = 1; n_scen = 0;
    for (int i = 0; i < 25; i++) begin n_scen += int'(explosion_SCEN); step(); end
    check("t4_held_scen", n_scen, E);
    place_btn = 0; step();
    place(); step(15);
    place_btn = 1; step(); place_btn = 0;
    n_scen = 0; n_bomb = 0;
    for (int i = 0; i < 12; i++) begin n_scen += int'(explosion_SCEN); n_bomb += int'(bomb_on); step(); end
    check("t4_cool_ignored", n_scen + n_bomb, 0);
    // 6: game_over mid-ARMED, async reset mid-EXPLODE
    place(); step(4);
    game_over = 1; step(); game_over = 0;
    check("t6_go_bomb", bomb_on, 0);
    n_scen = 0;
    for (int i = 0; i < 20; i++) begin n_scen += int'(explosion_SCEN); step(); end
    check("t6_go_scen", n_scen, 0);
    place(); step(F + 1);
    check("t6_pre_scen", explosion_SCEN, 1);
    reset = 1; #1;
    check("t6_rst_scen", explosion_SCEN, 0);
    check("t6_rst_hit", player_hit, 0);
    check("t6_rst_exy", {e_x, e_y}, 0);
    step(); reset = 0; step();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) place_btn = ~place_btn;
      game_over = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) begin
        b_x = 10'($urandom_range(100, 820)); b_y = 10'($urandom_range(10, 540));
      end else if ($urandom_range(0, 7) == 0) begin
        b_x = clampv(m_ex - 70 + int'($urandom_range(0, 140)));
        b_y = clampv(m_ey - 70 + int'($urandom_range(0, 140)));
      end
      v_x = clampv(m_ex - 60 + int'($urandom_range(0, 140)));
      v_y = clampv(m_ey - 60 + int'($urandom_range(0, 140)));
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
